// File: rtl/bpred_resolution_queue_pkg.sv
// Shared definitions for the branch resolution queue.
// Entry layout: {index, prediction}, prediction in bit 0.
package bpred_resolution_queue_pkg;
   localparam int BPRED_WIDTH_DEF = 9;
   localparam int DEPTH_DEF = 4;
   localparam int ENTRY_PRED_BIT = 0;
   localparam int ENTRY_IDX_LSB = 1;
endpackage

// File: rtl/bpred_resolution_queue_if.sv
// Fetch push, ALU resolve and counter-table update signals.
// Master drives the requests, slave is the queue.
interface bpred_resolution_queue_if #(
   parameter int BPRED_WIDTH = 9,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                   i_Fetch_Valid;
   logic [BPRED_WIDTH-1:0] i_Fetch_Index;
   logic                   i_Fetch_Prediction;
   logic                   o_Full;
   logic                   o_Empty;
   logic [CW-1:0]          o_Count;
   logic                   i_ALU_Branch_Valid;
   logic                   i_ALU_Branch_Outcome;
   logic                   i_Flush;
   logic                   o_Resolution_Valid;
   logic [BPRED_WIDTH-1:0] o_Resolution_Index;
   logic                   o_Resolution_Outcome;
   logic                   o_Mispredict;
   logic                   o_Underflow;

   modport master (
      output i_Fetch_Valid, i_Fetch_Index, i_Fetch_Prediction,
      output i_ALU_Branch_Valid, i_ALU_Branch_Outcome, i_Flush,
      input  o_Full, o_Empty, o_Count,
      input  o_Resolution_Valid, o_Resolution_Index,
      input  o_Resolution_Outcome, o_Mispredict, o_Underflow
   );

   modport slave (
      input  i_Fetch_Valid, i_Fetch_Index, i_Fetch_Prediction,
      input  i_ALU_Branch_Valid, i_ALU_Branch_Outcome, i_Flush,
      output o_Full, o_Empty, o_Count,
      output o_Resolution_Valid, o_Resolution_Index,
      output o_Resolution_Outcome, o_Mispredict, o_Underflow
   );
endinterface

// File: rtl/bpred_entry_fifo.sv
// In-order storage of predicted branches with push/pop/flush.
// Status flags are registered from the next count.
module bpred_entry_fifo #(
   parameter int W = 9,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W:0]    push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [W:0]    head_data,
   output logic          pop_ack,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [W:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic [CW-1:0] count_n;

   assign pop_ack   = pop && !empty;
   assign do_push   = push && (!full || pop_ack) && !flush;
   assign head_data = mem[rd_ptr];

   always_comb begin
      count_n = count;
      if (flush)
         count_n = '0;
      else if (do_push && !pop_ack)
         count_n = count + 1'b1;
      else if (!do_push && pop_ack)
         count_n = count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         // flush drops everything behind the head being resolved
         if (flush)
            rd_ptr <= wr_ptr;
         else if (pop_ack)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         count <= count_n;
         empty <= (count_n == '0);
         full  <= (count_n == CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/bpred_resolution_queue.sv
// Tracks predicted branches until the ALU resolves them and
// drives the counter-table update strobe one cycle later.
module bpred_resolution_queue
   import bpred_resolution_queue_pkg::*;
#(
   parameter int BPRED_WIDTH = BPRED_WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input logic                     i_Clk,
   input logic                     i_Reset_n,
   bpred_resolution_queue_if.slave bus
);
   logic [BPRED_WIDTH:0]   head;
   logic                   pop_ack;
   logic                   full;
   logic                   empty;
   logic [CW-1:0]          count;
   logic                   res_valid;
   logic [BPRED_WIDTH-1:0] res_index;
   logic                   res_outcome;
   logic                   mispredict;
   logic                   underflow;

   bpred_entry_fifo #(
      .W     (BPRED_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (i_Clk),
      .rst_n     (i_Reset_n),
      .push      (bus.i_Fetch_Valid),
      .push_data ({bus.i_Fetch_Index, bus.i_Fetch_Prediction}),
      .pop       (bus.i_ALU_Branch_Valid),
      .flush     (bus.i_Flush),
      .head_data (head),
      .pop_ack   (pop_ack),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         res_valid   <= 1'b0;
         res_index   <= '0;
         res_outcome <= 1'b0;
         mispredict  <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         res_valid  <= pop_ack;
         mispredict <= pop_ack &&
            (head[ENTRY_PRED_BIT] ^ bus.i_ALU_Branch_Outcome);
         if (pop_ack) begin
            res_index   <= head[BPRED_WIDTH:ENTRY_IDX_LSB];
            res_outcome <= bus.i_ALU_Branch_Outcome;
         end
         // a resolve with nothing in flight is a pipeline bug; keep it visible
         if (bus.i_ALU_Branch_Valid && empty)
            underflow <= 1'b1;
      end
   end

   assign bus.o_Full               = full;
   assign bus.o_Empty              = empty;
   assign bus.o_Count              = count;
   assign bus.o_Resolution_Valid   = res_valid;
   assign bus.o_Resolution_Index   = res_index;
   assign bus.o_Resolution_Outcome = res_outcome;
   assign bus.o_Mispredict         = mispredict;
   assign bus.o_Underflow          = underflow;
endmodule

// File: tb/tb_bpred_resolution_queue.sv
// Directed bench for bpred_resolution_queue with a queue-based
// reference model checked after every clock.
module tb_bpred_resolution_queue;
   import bpred_resolution_queue_pkg::*;

   localparam int W = BPRED_WIDTH_DEF;
   localparam int D = DEPTH_DEF;

   typedef struct {
      logic [W-1:0] idx;
      logic         pred;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bpred_resolution_queue_if #(.BPRED_WIDTH(W), .DEPTH(D)) bus ();

   bpred_resolution_queue #(.BPRED_WIDTH(W), .DEPTH(D)) dut (
      .i_Clk     (clk),
      .i_Reset_n (rst_n),
      .bus       (bus.slave)
   );

   int tests = 0;
   int fails = 0;

   ent_t         mq[$];
   logic         e_valid, e_out, e_mis, e_under;
   logic [W-1:0] e_idx;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic compare();
      chk("valid", 32'(bus.o_Resolution_Valid), 32'(e_valid));
      chk("index", 32'(bus.o_Resolution_Index), 32'(e_idx));
      chk("outcome", 32'(bus.o_Resolution_Outcome), 32'(e_out));
      chk("mispredict", 32'(bus.o_Mispredict), 32'(e_mis));
      chk("underflow", 32'(bus.o_Underflow), 32'(e_under));
      chk("count", 32'(bus.o_Count), 32'(mq.size()));
      chk("empty", 32'(bus.o_Empty), 32'(mq.size() == 0));
      chk("full", 32'(bus.o_Full), 32'(mq.size() == D));
   endtask

   task automatic model_step(logic fv, logic [W-1:0] fi, logic fp,
                             logic av, logic ao, logic fl);
      ent_t h;
      bit pop, push;
      pop  = av && (mq.size() > 0);
      push = fv && (mq.size() < D || pop) && !fl;
      if (av && mq.size() == 0) e_under = 1'b1;
      if (pop) begin
         h       = mq.pop_front();
         e_valid = 1'b1;
         e_idx   = h.idx;
         e_out   = ao;
         e_mis   = h.pred ^ ao;
      end else begin
         e_valid = 1'b0;
         e_mis   = 1'b0;
      end
      if (fl) mq.delete();
      else if (push) mq.push_back('{idx: fi, pred: fp});
   endtask

   task automatic drive(logic fv, logic [W-1:0] fi, logic fp,
                        logic av, logic ao, logic fl);
      bus.i_Fetch_Valid        = fv;
      bus.i_Fetch_Index        = fi;
      bus.i_Fetch_Prediction   = fp;
      bus.i_ALU_Branch_Valid   = av;
      bus.i_ALU_Branch_Outcome = ao;
      bus.i_Flush              = fl;
      @(posedge clk);
      model_step(fv, fi, fp, av, ao, fl);
      #1;
      compare();
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push(logic [W-1:0] fi, logic fp);
      drive(1'b1, fi, fp, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic resolve(logic ao);
      drive(1'b0, '0, 1'b0, 1'b1, ao, 1'b0);
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #2;
      mq.delete();
      e_valid = 0; e_idx = '0; e_out = 0; e_mis = 0; e_under = 0;
      chk("rst_empty", 32'(bus.o_Empty), 32'd1);
      chk("rst_count", 32'(bus.o_Count), 32'd0);
      chk("rst_full", 32'(bus.o_Full), 32'd0);
      chk("rst_valid", 32'(bus.o_Resolution_Valid), 32'd0);
      chk("rst_underflow", 32'(bus.o_Underflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.i_Fetch_Valid = 0;
      bus.i_Fetch_Index = '0;
      bus.i_Fetch_Prediction = 0;
      bus.i_ALU_Branch_Valid = 0;
      bus.i_ALU_Branch_Outcome = 0;
      bus.i_Flush = 0;
      rst_n = 1'b1;
      @(negedge clk);
      do_reset();

      // single mispredicted branch, one-cycle pulse
      push(9'd5, 1'b1);
      resolve(1'b0);
      chk("p5_valid", 32'(bus.o_Resolution_Valid), 32'd1);
      chk("p5_index", 32'(bus.o_Resolution_Index), 32'd5);
      chk("p5_outcome", 32'(bus.o_Resolution_Outcome), 32'd0);
      chk("p5_mis", 32'(bus.o_Mispredict), 32'd1);
      idle();
      chk("p5_pulse", 32'(bus.o_Resolution_Valid), 32'd0);
      chk("p5_hold", 32'(bus.o_Resolution_Index), 32'd5);

      // fill, overflow push dropped, drain in order
      for (int i = 1; i <= 4; i++) push(W'(i), 1'(i));
      push(9'd9, 1'b1);
      chk("ovf_full", 32'(bus.o_Full), 32'd1);
      chk("ovf_count", 32'(bus.o_Count), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         resolve(1'b1);
         chk("drain_idx", 32'(bus.o_Resolution_Index), 32'(i));
         chk("drain_mis", 32'(bus.o_Mispredict), 32'(~i & 1));
      end
      chk("drain_empty", 32'(bus.o_Empty), 32'd1);

      // full + simultaneous push/pop, repeated for pointer wrap
      for (int r = 0; r < 3; r++) begin
         for (int i = 1; i <= 4; i++) push(W'(i + 16 * r), 1'b0);
         drive(1'b1, W'(7 + 16 * r), 1'b1, 1'b1, 1'b0, 1'b0);
         chk("pp_count", 32'(bus.o_Count), 32'd4);
         chk("pp_idx", 32'(bus.o_Resolution_Index), 32'(1 + 16 * r));
         for (int i = 0; i < 4; i++) resolve(1'b1);
         chk("pp_last", 32'(bus.o_Resolution_Index), 32'(7 + 16 * r));
         chk("pp_lastmis", 32'(bus.o_Mispredict), 32'd0);
      end

      // flush with same-cycle resolve and push
      push(9'd10, 1'b0);
      push(9'd11, 1'b1);
      push(9'd12, 1'b0);
      drive(1'b1, 9'd13, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("fl_valid", 32'(bus.o_Resolution_Valid), 32'd1);
      chk("fl_idx", 32'(bus.o_Resolution_Index), 32'd10);
      chk("fl_mis", 32'(bus.o_Mispredict), 32'd1);
      chk("fl_empty", 32'(bus.o_Empty), 32'd1);
      resolve(1'b0);
      chk("uf_flag", 32'(bus.o_Underflow), 32'd1);
      chk("uf_nostrobe", 32'(bus.o_Resolution_Valid), 32'd0);

      // push into empty queue with same-cycle resolve: no bypass
      drive(1'b1, 9'd300, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("nb_valid", 32'(bus.o_Resolution_Valid), 32'd0);
      resolve(1'b0);
      chk("nb_idx", 32'(bus.o_Resolution_Index), 32'd300);

      // reset mid-traffic
      push(9'd20, 1'b1);
      push(9'd21, 1'b0);
      do_reset();
      idle();
      resolve(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
